mmio_mailbox: RTL

- Memory-mapped responder on the CPU data bus, decoding a 16-byte window at BASE_ADDR.
- Host/driver side uses the Ext_* write port to load a parameter and flush results.
- CPU stores result bytes, which are buffered in a FIFO and popped by the host through a valid/ready handshake.
- CPU signals completion by writing the DONE register. Sits beside data memory; `hit` steers the load mux.

---
 rtl/mmio_mailbox.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mmio_mailbox.sv
// Memory-mapped CPU/host mailbox: a parameter register, a byte result FIFO popped by the host,
// and a small run-state machine the CPU advances by accessing the 16-byte window.
module mmio_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CW         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ext_MemWrite,
    input  logic [31:0] Ext_DataAdr,
    input  logic [31:0] Ext_WriteData,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OFF_RESULT = 2'd0;
    localparam logic [1:0] OFF_PARAM  = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     param_q, param_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic cpu_in_win, host_in_win;
    logic host_flush, host_param, cpu_push, cpu_done;
    logic fifo_full, fifo_empty, do_push, do_pop, ovf_set;
    logic unused_bits;

    assign cpu_in_win  = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign host_in_win = (Ext_DataAdr[31:4] == BASE_ADDR[31:4]);

    assign host_flush = Ext_MemWrite && host_in_win && (Ext_DataAdr[3:2] == OFF_RESULT);
    assign host_param = Ext_MemWrite && host_in_win && (Ext_DataAdr[3:2] == OFF_PARAM);
    assign cpu_push   = MemWrite && cpu_in_win && (DataAdr[3:2] == OFF_RESULT);
    assign cpu_done   = MemWrite && cpu_in_win && (DataAdr[3:2] == OFF_DONE);

    // Byte lanes and upper data bits carry no meaning for this block.
    assign unused_bits = ^{DataAdr[1:0], Ext_DataAdr[1:0], WriteData[31:8]};

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Flush dominates: it suppresses the pop and the push, so neither can set overflow.
    assign do_pop  = !fifo_empty && out_ready && !host_flush;
    assign do_push = cpu_push && !host_flush && (!fifo_full || do_pop);
    assign ovf_set = cpu_push && !host_flush && fifo_full && !do_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        param_d    = host_param ? Ext_WriteData : param_q;
        if (host_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (ovf_set) overflow_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            param_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            param_q    <= param_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is left unreset; out_data is masked while empty, so stale entries never escape.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host_param) state_d = ARMED;
            ARMED:   if (cpu_in_win) state_d = RUNNING;
            RUNNING: if (cpu_done)   state_d = DONE;
            DONE:    if (host_flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done      = (state_q == DONE);
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
        overflow  = overflow_q;
    end

    always_comb begin
        hit      = cpu_in_win;
        ReadData = '0;
        if (cpu_in_win) begin
            case (DataAdr[3:2])
                OFF_RESULT: ReadData = {24'b0, out_data};
                OFF_PARAM:  ReadData = param_q;
                OFF_STATUS: ReadData = 32'({overflow_q, state_q, count_q});
                OFF_DONE:   ReadData = {31'b0, done};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule
